// File: rtl/enc_pkg.sv
// Shared widths and FSM state type for the sequential 8-to-3 priority encoder.
package enc_pkg;

  localparam int N_IN   = 8;
  localparam int N_CODE = 3;
  localparam int CNT_W  = $clog2(N_IN + 1);

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;

endpackage

// File: rtl/priority_encoder_8to3.sv
// Combinational priority encoder: index of the highest set bit plus an any-bit flag.
module priority_encoder_8to3
  import enc_pkg::*;
(
  input  logic [N_IN-1:0]   in_i,
  output logic [N_CODE-1:0] idx_o,
  output logic              any_o
);

  // Ascending scan so the highest set bit is the last write and wins.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (in_i[i]) idx_o = N_CODE'(i);
    end
  end

  assign any_o = |in_i;

endmodule

// File: rtl/priority_encoder_8to3_seq.sv
// Captures a multi-hot vector and emits its set-bit indices one per handshake, highest first.
module priority_encoder_8to3_seq
  import enc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic [N_IN-1:0]   x,
  output logic [N_CODE-1:0] y,
  output logic              y_valid,
  input  logic              y_ready,
  output logic              y_last,
  output logic [CNT_W-1:0]  cnt,
  output logic              zero
);

  state_e             state_q;
  logic [N_IN-1:0]    pend_q;
  logic [N_IN-1:0]    pend_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   popcnt;
  logic               zero_q;
  logic [N_CODE-1:0]  top_idx;
  logic               pend_any;
  logic               single;

  priority_encoder_8to3 u_enc (
    .in_i  (pend_q),
    .idx_o (top_idx),
    .any_o (pend_any)
  );

  always_comb begin
    popcnt = '0;
    for (int i = 0; i < N_IN; i++) begin
      popcnt = popcnt + CNT_W'(x[i]);
    end
  end

  // Clearing the lowest set bit leaves nothing exactly when one bit remains.
  assign single = pend_any && ((pend_q & (pend_q - N_IN'(1))) == '0);
  assign pend_d = pend_q & ~(N_IN'(1) << top_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      zero_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (x_valid) begin
            pend_q <= x;
            cnt_q  <= popcnt;
            zero_q <= (x == '0);
            if (x != '0) state_q <= EMIT;
          end
        end
        EMIT: begin
          if (y_ready) begin
            pend_q <= pend_d;
            if (single) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign x_ready = (state_q == IDLE);
  assign y_valid = (state_q == EMIT);
  assign y       = y_valid ? top_idx : '0;
  assign y_last  = y_valid && single;
  assign cnt     = cnt_q;
  assign zero    = zero_q;

endmodule

// File: tb/tb_priority_encoder_8to3_seq.sv
// Scoreboard bench: expected indices queued at acceptance, a monitor pops them on each y handshake.
module tb_priority_encoder_8to3_seq;

  typedef struct {
    logic [2:0] idx;
    logic       last;
  } expEntry_t;

  typedef struct {
    logic [3:0] cnt;
    logic       zero;
  } accept_t;

  logic       clk;
  logic       rst;
  logic       x_valid;
  logic       x_ready;
  logic [7:0] x;
  logic [2:0] y;
  logic       y_valid;
  logic       y_ready;
  logic       y_last;
  logic [3:0] cnt;
  logic       zero;

  int checks = 0;
  int errors = 0;
  bit randomReady = 0;

  expEntry_t expQ[$];
  accept_t   acceptQ[$];

  logic       prevValid = 0;
  logic       prevReady = 0;
  logic [2:0] prevY = 0;
  logic       prevLast = 0;
  logic       prevRst = 1;
  logic [3:0] expCnt = 0;

  priority_encoder_8to3_seq dut (
    .clk     (clk),
    .rst     (rst),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .x       (x),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .y_last  (y_last),
    .cnt     (cnt),
    .zero    (zero)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Offers v until accepted, then records the reference response for that vector.
  task automatic applyStimulus(input logic [7:0] v, input bit keepValid, output int waited);
    expEntry_t e;
    accept_t   a;
    int        remaining;
    bit        ok;
    x       = v;
    x_valid = 1;
    waited  = 0;
    ok      = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (x_ready) ok = 1;
      else waited++;
    end
    if (!ok) begin
      checkOutput("accept_timeout", {31'b0, ok}, 1);
      x_valid = 0;
      return;
    end
    @(posedge clk);
    #1;
    if (!keepValid) x_valid = 0;
    remaining = $countones(v);
    a.cnt  = remaining[3:0];
    a.zero = (v == 8'h00);
    acceptQ.push_back(a);
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        remaining--;
        e.idx  = i[2:0];
        e.last = (remaining == 0);
        expQ.push_back(e);
      end
    end
  endtask

  task automatic waitDrain();
    bit drained;
    drained = 0;
    for (int k = 0; k < 200 && !drained; k++) begin
      @(negedge clk);
      if (expQ.size() == 0 && !y_valid) drained = 1;
    end
    checkOutput("drain", {31'b0, drained}, 1);
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (randomReady) y_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: protocol invariants every cycle, scoreboard pop on every y handshake.
  always @(negedge clk) begin
    expEntry_t e;
    accept_t   a;
    if (!rst) begin
      if (prevRst) expCnt = 0;
      checkOutput("x_ready_vs_y_valid", {31'b0, x_ready}, {31'b0, !y_valid});
      if (!y_valid) begin
        checkOutput("idle_y", {29'b0, y}, 0);
        checkOutput("idle_y_last", {31'b0, y_last}, 0);
      end
      if (!prevRst && prevValid && !prevReady) begin
        checkOutput("hold_y_valid", {31'b0, y_valid}, 1);
        checkOutput("hold_y", {29'b0, y}, {29'b0, prevY});
        checkOutput("hold_y_last", {31'b0, y_last}, {31'b0, prevLast});
      end
      if (acceptQ.size() > 0) begin
        a = acceptQ.pop_front();
        expCnt = a.cnt;
        checkOutput("zero_pulse", {31'b0, zero}, {31'b0, a.zero});
      end else begin
        checkOutput("zero_quiet", {31'b0, zero}, 0);
      end
      checkOutput("cnt", {28'b0, cnt}, {28'b0, expCnt});
      if (y_valid && y_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_y", {31'b0, y_valid}, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("y_index", {29'b0, y}, {29'b0, e.idx});
          checkOutput("y_last", {31'b0, y_last}, {31'b0, e.last});
        end
      end
    end
    prevValid = y_valid;
    prevReady = y_ready;
    prevY     = y;
    prevLast  = y_last;
    prevRst   = rst;
  end

  initial begin
    int         w;
    int         w2;
    logic [7:0] v;
    logic [2:0] seqA5 [4];
    seqA5 = '{3'd7, 3'd5, 3'd2, 3'd0};

    rst = 1; x_valid = 0; x = 8'h00; y_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    checkOutput("reset_y_valid", {31'b0, y_valid}, 0);
    checkOutput("reset_y", {29'b0, y}, 0);
    checkOutput("reset_y_last", {31'b0, y_last}, 0);
    checkOutput("reset_cnt", {28'b0, cnt}, 0);
    checkOutput("reset_zero", {31'b0, zero}, 0);
    checkOutput("reset_x_ready", {31'b0, x_ready}, 1);
    @(posedge clk); #1;

    $display("[TB] single-bit vector 0x10");
    y_ready = 1;
    applyStimulus(8'h10, 0, w);
    @(negedge clk);
    checkOutput("single_y", {29'b0, y}, 4);
    checkOutput("single_valid", {31'b0, y_valid}, 1);
    checkOutput("single_last", {31'b0, y_last}, 1);
    checkOutput("single_cnt", {28'b0, cnt}, 1);
    @(negedge clk);
    checkOutput("single_idle_valid", {31'b0, y_valid}, 0);
    checkOutput("single_idle_x_ready", {31'b0, x_ready}, 1);
    @(posedge clk); #1;

    $display("[TB] multi-bit vector 0xA5");
    applyStimulus(8'hA5, 0, w);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("a5_y", {29'b0, y}, {29'b0, seqA5[k]});
      checkOutput("a5_last", {31'b0, y_last}, (k == 3) ? 32'd1 : 32'd0);
    end
    waitDrain();

    $display("[TB] backpressure on 0x81");
    y_ready = 0;
    applyStimulus(8'h81, 0, w);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("bp_y", {29'b0, y}, 7);
      checkOutput("bp_valid", {31'b0, y_valid}, 1);
      @(posedge clk); #1;
    end
    y_ready = 1;
    @(negedge clk);
    checkOutput("bp_release_y", {29'b0, y}, 7);
    waitDrain();

    $display("[TB] zero vector");
    applyStimulus(8'h00, 0, w);
    @(negedge clk);
    checkOutput("zero_now", {31'b0, zero}, 1);
    checkOutput("zero_y_valid", {31'b0, y_valid}, 0);
    checkOutput("zero_x_ready", {31'b0, x_ready}, 1);
    @(negedge clk);
    checkOutput("zero_after", {31'b0, zero}, 0);
    checkOutput("zero_x_ready_after", {31'b0, x_ready}, 1);
    @(posedge clk); #1;

    $display("[TB] reset in the middle of 0xFF");
    applyStimulus(8'hFF, 0, w);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    y_ready = 0;
    expQ.delete();
    @(posedge clk); #1;
    rst = 0;
    y_ready = 1;
    @(negedge clk);
    checkOutput("midrst_y_valid", {31'b0, y_valid}, 0);
    checkOutput("midrst_cnt", {28'b0, cnt}, 0);
    checkOutput("midrst_x_ready", {31'b0, x_ready}, 1);
    @(posedge clk); #1;

    $display("[TB] full vector with blocked input");
    applyStimulus(8'hFF, 1, w);
    applyStimulus(8'h3C, 0, w2);
    checkOutput("blocked_wait_cycles", w2, 8);
    waitDrain();

    $display("[TB] random phase");
    randomReady = 1;
    for (int n = 0; n < 40; n++) begin
      v = 8'($urandom);
      if ($urandom_range(0, 7) == 0) v = 8'h00;
      applyStimulus(v, 0, w);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    waitDrain();
    randomReady = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/priority_encoder_8to3_seq.md
PRIORITY_ENCODER_8TO3_SEQ -- requirements
Module: priority_encoder_8to3_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port x_valid, input, 1 bit: request vector on x is offered.
REQ-004 SHALL have port x_ready, output, 1 bit: block can accept a vector.
REQ-005 SHALL have port x, input, 8 bits: multi-hot request vector; bit i corresponds to code i.
REQ-006 SHALL have port y, output, 3 bits: encoded index of the current highest set bit.
REQ-007 SHALL have port y_valid, output, 1 bit: y is valid.
REQ-008 SHALL have port y_ready, input, 1 bit: consumer accepts y.
REQ-009 SHALL have port y_last, output, 1 bit: current y is the final index of the captured vector.
REQ-010 SHALL have port cnt, output, 4 bits: population count of the last accepted vector (0..8).
REQ-011 SHALL have port zero, output, 1 bit: one-cycle pulse when an all-zero vector is accepted.

Function
REQ-012 SHALL implement the states IDLE and EMIT.
REQ-013 SHALL drive x_ready=1 in IDLE and x_ready=0 in EMIT.
REQ-014 SHALL accept a vector on the rising edge with x_valid&&x_ready, capturing x into internal register pend[7:0] and popcount(x) into cnt.
REQ-015 SHALL, on accepting a nonzero vector, enter EMIT; y_valid SHALL rise in the next cycle, giving one-cycle acceptance-to-output latency.
REQ-016 SHALL, on accepting x=8'h00, stay in IDLE, pulse zero=1 for exactly the following cycle, set cnt=0, and keep y_valid=0.
REQ-017 SHALL drive y in EMIT as the index of the highest set bit of pend, with bit 7 having highest priority.
REQ-018 SHALL hold y, y_valid and y_last stable while y_valid&&!y_ready.
REQ-019 SHALL, on a y_valid&&y_ready handshake, clear bit y of pend; the next index SHALL appear in the following cycle with no bubble.
REQ-020 SHALL drive y_last=1 exactly when pend has a single set bit.
REQ-021 SHALL, on a handshake with y_last=1, return to IDLE with y_valid=0 and x_ready=1 in the next cycle; back-to-back vectors therefore SHALL cost one idle cycle each.
REQ-022 SHALL ignore x_valid and x while in EMIT; no vector is lost because x_ready=0.
REQ-023 SHALL drive y=3'd0 and y_last=0 whenever y_valid=0.
REQ-024 SHALL make the number of y handshakes per accepted vector equal cnt, emitted in strictly descending index order.

Reset
REQ-025 SHALL, while rst=1 at a clock edge, set state=IDLE, pend=0, cnt=0, zero=0, y_valid=0, y=0 and y_last=0; x_ready SHALL be 1 from the first cycle after reset.
REQ-026 SHALL give rst priority over all handshakes; rst asserted mid-EMIT SHALL discard remaining indices, with no further y_valid.

Structure
REQ-027 SHALL place the state enum (IDLE, EMIT) and the width constants (N_IN=8, N_CODE=3) in shared package enc_pkg.
REQ-028 SHALL have a combinational sub-module priority_encoder_8to3 (8-bit in, 3-bit index, any-bit flag) instantiated on pend; it is the inverse of the team's 3-to-8 decoder.
REQ-029 SHALL compute popcount inline in the top module.

Verification
REQ-030 SHALL cover the single-bit case: x=8'h10 with y_ready=1 -> one cycle later y=4, y_valid=1, y_last=1, cnt=1; IDLE on the next cycle.
REQ-031 SHALL cover the multi-bit case: x=8'hA5 with y_ready=1 -> y=7,5,2,0 on consecutive cycles, y_last only with 0, cnt=4.
REQ-032 SHALL cover backpressure: x=8'h81 with y_ready=0 for 3 cycles -> y=7 held stable 4 cycles, then y=0 with y_last=1.
REQ-033 SHALL cover the zero vector: x=8'h00 -> zero pulses 1 cycle, y_valid stays 0, x_ready stays 1.
REQ-034 SHALL cover reset mid-operation: x=8'hFF, rst after 2 handshakes -> y_valid=0, cnt=0, x_ready=1 the cycle after reset.
REQ-035 SHALL cover the full vector plus a blocked input: x=8'hFF, with x_valid held high and x changed during EMIT -> y=7..0 in 8 handshakes, cnt=8, and the new vector accepted only after return to IDLE.
